// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body sequencer.
// Latency: n/a (types, constants and a constant-layout helper only).
// Backpressure: n/a.
package snake_pkg;

  localparam int GRID_DIM  = 16;
  localparam int MAX_LEN   = 255;
  localparam int POS_DEPTH = 256;

  typedef logic [7:0] pos_t;
  typedef pos_t [POS_DEPTH-1:0] pos_arr_t;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    SCAN,
    UPDATE,
    DEAD
  } state_t;

  // Opposite directions differ only in bit 0 with this encoding.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a ^ b) == 2'b01;
  endfunction

  // Start layout: head at start_pos, body trailing leftward, rest cleared.
  function automatic pos_arr_t init_layout(input pos_t start_pos, input int init_len);
    pos_arr_t arr;
    arr = '0;
    for (int k = 0; k < POS_DEPTH; k++) begin
      if (k < init_len) begin
        arr[k] = start_pos - pos_t'(k);
      end
    end
    return arr;
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Next head cell from current head and direction, with wall detection. SNAKE_WRAP_EN: wrap at edges.
// Latency: purely combinational.
// Backpressure: none.
module snake_next_head
  import snake_pkg::*;
(
  input  pos_t       head,
  input  dir_t       dir,
  output pos_t       nxt,
  output logic       wall_hit
);

  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] row_n;
  logic [3:0] col_n;

  assign row = head[7:4];
  assign col = head[3:0];

  // 4-bit step; crossing an edge naturally wraps modulo the grid size
  always_comb begin
    row_n = row;
    col_n = col;
    case (dir)
      UP:      row_n = row - 4'd1;
      DOWN:    row_n = row + 4'd1;
      LEFT:    col_n = col - 4'd1;
      default: col_n = col + 4'd1;
    endcase
    nxt = {row_n, col_n};
  end

`ifdef SNAKE_WRAP_EN
  // Edges wrap, so walls never stop the snake
  assign wall_hit = 1'b0;
`else
  localparam logic [3:0] LAST = 4'(GRID_DIM - 1);
  // Stepping off any side of the grid is fatal
  assign wall_hit = ((dir == UP)    && (row == 4'd0)) ||
                    ((dir == DOWN)  && (row == LAST)) ||
                    ((dir == LEFT)  && (col == 4'd0)) ||
                    ((dir == RIGHT) && (col == LAST));
`endif

endmodule

// File: rtl/snake_ctrl.sv
// Snake body sequencer: per tick move head, check walls/self (one segment per cycle), shift/grow body. Optional SNAKE_WRAP_EN.
// Latency: tick at edge N -> body updated at edge N+S+2 (S = self-collision compares).
// Backpressure: none; ticks arriving outside RUN are dropped, not queued.
module snake_ctrl
  import snake_pkg::*;
#(
  parameter int   INIT_LEN  = 3,
  parameter pos_t START_POS = 8'h88
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start,
  input  dir_t       dir_in,
  input  pos_t       food_pos,
  output pos_arr_t   pos,
  output logic [7:0] length,
  output logic       eat,
  output logic       game_over
);

  localparam pos_arr_t   INIT_POS   = init_layout(START_POS, INIT_LEN);
  localparam logic [7:0] INIT_LEN_V = 8'(INIT_LEN);
  localparam logic [7:0] MAX_LEN_V  = 8'(MAX_LEN);

  state_t     state_q, state_d;
  dir_t       dir_q,   dir_d;
  pos_t       nxt_q,   nxt_d;
  logic       grow_q,  grow_d;
  logic [7:0] k_q,     k_d;
  logic [7:0] len_q,   len_d;
  pos_arr_t   pos_q,   pos_d;

  dir_t       dir_eff;
  pos_t       nxt_w;
  logic       wall_w;
  logic [7:0] scan_limit;
  logic       scan_done;
  logic       scan_hit;

  // A reverse request would fold the snake onto itself, so it is ignored
  assign dir_eff = is_reverse(dir_in, dir_q) ? dir_q : dir_in;

  snake_next_head u_next_head (
    .head     (pos_q[0]),
    .dir      (dir_eff),
    .nxt      (nxt_w),
    .wall_hit (wall_w)
  );

  // The tail cell vacates on a plain move, so it is only checked when growing
  assign scan_limit = grow_q ? len_q : (len_q - 8'd1);
  assign scan_done  = (k_q == scan_limit);
  assign scan_hit   = (nxt_q == pos_q[k_q]);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (tick)  state_d = wall_w ? DEAD : SCAN;
      SCAN: begin
        if (scan_done)     state_d = UPDATE;
        else if (scan_hit) state_d = DEAD;
      end
      UPDATE:  state_d = RUN;
      DEAD:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    eat       = (state_q == UPDATE) && grow_q;
    game_over = (state_q == DEAD);
  end

  // Datapath next values: move latch on tick, scan index, body shift, restart reload
  always_comb begin
    dir_d  = dir_q;
    nxt_d  = nxt_q;
    grow_d = grow_q;
    k_d    = k_q;
    len_d  = len_q;
    pos_d  = pos_q;
    case (state_q)
      RUN: begin
        if (tick) begin
          dir_d  = dir_eff;
          nxt_d  = nxt_w;
          grow_d = (nxt_w == food_pos);
          k_d    = 8'd0;
        end
      end
      SCAN: begin
        if (!scan_done && !scan_hit) begin
          k_d = k_q + 8'd1;
        end
      end
      UPDATE: begin
        for (int k = 1; k < MAX_LEN; k++) begin
          pos_d[k] = pos_q[k-1];
        end
        pos_d[0] = nxt_q;
        // At full length the tail simply falls off the end of the shift
        if (grow_q && (len_q < MAX_LEN_V)) begin
          len_d = len_q + 8'd1;
        end
      end
      DEAD: begin
        if (start) begin
          pos_d = INIT_POS;
          len_d = INIT_LEN_V;
          dir_d = RIGHT;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q  <= RIGHT;
      nxt_q  <= '0;
      grow_q <= 1'b0;
      k_q    <= '0;
      len_q  <= INIT_LEN_V;
      pos_q  <= INIT_POS;
    end else begin
      dir_q  <= dir_d;
      nxt_q  <= nxt_d;
      grow_q <= grow_d;
      k_q    <= k_d;
      len_q  <= len_d;
      pos_q  <= pos_d;
    end
  end

  assign pos    = pos_q;
  assign length = len_q;

endmodule

// File: tb/tb_snake_ctrl.sv
// Directed bench for snake_ctrl with a behavioural body model and expectation queue.
// Latency: checks move latency S+2 and collision timing against the model.
// Backpressure: checks ticks outside RUN are dropped.
module tb_snake_ctrl;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick;
  logic       start;
  dir_t       dir_in;
  pos_t       food_pos;
  pos_arr_t   pos;
  logic [7:0] length;
  logic       eat;
  logic       game_over;

  always #5 clk = ~clk;

  snake_ctrl #(
    .INIT_LEN  (3),
    .START_POS (8'h88)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .start     (start),
    .dir_in    (dir_in),
    .food_pos  (food_pos),
    .pos       (pos),
    .length    (length),
    .eat       (eat),
    .game_over (game_over)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic             dead;
    logic [15:0]      lat;
    logic [7:0]       len;
    logic [7:0]       eats;
    logic [15:0][7:0] body;
  } exp_t;

  exp_t sb[$];
  pos_t mbody[$];
  dir_t mdir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mbody = {8'h88, 8'h87, 8'h86};
    mdir  = RIGHT;
  endtask

  // Behavioural move: direction filter, step, wall, self check, shift/grow
  task automatic model_move(input dir_t d, input pos_t food, output exp_t e);
    int   r, c, hit, lim;
    logic grow, wall, rev;
    pos_t nh;
    rev = (mdir == UP && d == DOWN) || (mdir == DOWN && d == UP) ||
          (mdir == LEFT && d == RIGHT) || (mdir == RIGHT && d == LEFT);
    if (!rev) mdir = d;
    r = int'(mbody[0][7:4]);
    c = int'(mbody[0][3:0]);
    case (mdir)
      UP:      r = r - 1;
      DOWN:    r = r + 1;
      LEFT:    c = c - 1;
      default: c = c + 1;
    endcase
    wall = (r < 0) || (r > 15) || (c < 0) || (c > 15);
`ifdef SNAKE_WRAP_EN
    wall = 1'b0;
`endif
    nh   = pos_t'((r & 15) * 16 + (c & 15));
    e    = '0;
    grow = 1'b0;
    if (wall) begin
      e.dead = 1'b1;
      e.lat  = 16'd0;
    end else begin
      grow = (nh == food);
      lim  = grow ? mbody.size() : mbody.size() - 1;
      hit  = -1;
      for (int k = 0; k < lim; k++) begin
        if (hit < 0 && mbody[k] == nh) hit = k;
      end
      if (hit >= 0) begin
        e.dead = 1'b1;
        e.lat  = 16'(hit + 1);
      end else begin
        mbody.push_front(nh);
        if (!grow) void'(mbody.pop_back());
        e.lat  = 16'(lim + 2);
        e.eats = grow ? 8'd1 : 8'd0;
      end
    end
    e.len = 8'(mbody.size());
    for (int k = 0; k < 16; k++) begin
      e.body[k] = (k < mbody.size()) ? mbody[k] : 8'h00;
    end
  endtask

  // Drive one tick, optionally inject a stray tick mid-move, then check the outcome
  task automatic run_tick(input string tag, input dir_t d, input pos_t food, input int extra_at);
    exp_t e, got;
    pos_t old_head;
    int   cyc, eats;
    logic done;
    model_move(d, food, e);
    sb.push_back(e);
    old_head = pos[0];
    dir_in   = d;
    food_pos = food;
    tick     = 1'b1;
    @(posedge clk); #1;
    tick     = 1'b0;
    dir_in   = dir_t'(~d);
    food_pos = 8'hFF;
    cyc  = 0;
    eats = 0;
    done = 1'b0;
    while (!done && cyc < 400) begin
      if (eat) eats++;
      if (pos[0] !== old_head || game_over) begin
        done = 1'b1;
      end else begin
        tick = (cyc == extra_at);
        @(posedge clk); #1;
        tick = 1'b0;
        cyc++;
      end
    end
    @(posedge clk); #1;
    if (eat) eats++;
    got = sb.pop_front();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_lat"},  cyc, 32'(got.lat));
    chk({tag, "_dead"}, 32'(game_over), 32'(got.dead));
    chk({tag, "_len"},  32'(length), 32'(got.len));
    chk({tag, "_eat"},  eats, 32'(got.eats));
    for (int k = 0; k < 16 && k < int'(got.len); k++) begin
      chk($sformatf("%s_pos%0d", tag, k), 32'(pos[k]), 32'(got.body[k]));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n  = 1'b0;
    tick     = 1'b0;
    start    = 1'b0;
    dir_in   = RIGHT;
    food_pos = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_len",  32'(length), 32'd3);
    chk("rst_go",   32'(game_over), 32'd0);
    chk("rst_eat",  32'(eat), 32'd0);
    chk("rst_pos0", 32'(pos[0]), 32'h88);
    chk("rst_pos1", 32'(pos[1]), 32'h87);
    chk("rst_pos2", 32'(pos[2]), 32'h86);
    chk("rst_pos3", 32'(pos[3]), 32'h00);
    chk("rst_pos255", 32'(pos[255]), 32'h00);

    // Tick while IDLE is dropped
    reset_n = 1'b1;
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("idle_tick_pos0", 32'(pos[0]), 32'h88);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_reset();

    run_tick("rev",   LEFT,  8'h00, -1);
    run_tick("grow",  RIGHT, 8'h8A, -1);
    start = 1'b1;
    run_tick("up",    UP,    8'h00, -1);
    start = 1'b0;
    run_tick("drev",  DOWN,  8'h00, -1);
    run_tick("grow2", LEFT,  8'h69, -1);
    run_tick("down",  DOWN,  8'h00, -1);
    run_tick("self",  RIGHT, 8'h00, -1);

    // Tick while DEAD is dropped and the body stays frozen
    tick   = 1'b1;
    dir_in = UP;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("dead_tick_pos0", 32'(pos[0]), 32'h79);
    chk("dead_tick_go",   32'(game_over), 32'd1);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_reset();
    chk("restart_go",   32'(game_over), 32'd0);
    chk("restart_len",  32'(length), 32'd3);
    chk("restart_pos0", 32'(pos[0]), 32'h88);
    chk("restart_pos2", 32'(pos[2]), 32'h86);
    chk("restart_pos3", 32'(pos[3]), 32'h00);

    for (int i = 0; i < 7; i++) run_tick($sformatf("walk%0d", i), RIGHT, 8'h00, -1);
    run_tick("wall", RIGHT, 8'h00, -1);

    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_reset();

    // Stray tick one cycle into SCAN must not produce a second move
    run_tick("xtick", RIGHT, 8'h00, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("xtick_hold_pos0", 32'(pos[0]), 32'h89);
    chk("xtick_hold_pos1", 32'(pos[1]), 32'h88);

    // Reset mid-SCAN returns to the start layout immediately
    dir_in = DOWN;
    tick   = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("arst_pos0", 32'(pos[0]), 32'h88);
    chk("arst_pos1", 32'(pos[1]), 32'h87);
    chk("arst_pos3", 32'(pos[3]), 32'h00);
    chk("arst_len",  32'(length), 32'd3);
    chk("arst_go",   32'(game_over), 32'd0);
    chk("arst_eat",  32'(eat), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
